// File: rtl/mytimer_pkg.sv
// Shared constants for the mytimer block: register map, CONTROL bit positions, STATUS bit.
// Used by both the default build and the MYTIMER_PRESCALER_EN build.
package mytimer_pkg;

   localparam logic [2:0] ADDR_CONTROL  = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_PRESCALE = 3'd3;
   localparam logic [2:0] ADDR_COUNT    = 3'd4;

   localparam int CTRL_RUN   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;

   localparam int STAT_READY = 0;

endpackage

// File: rtl/mytimer_prescaler.sv
// Prescale counter: while enabled, emits a one-cycle tick every limit+1 cycles.
// Instantiated by mytimer_core only when MYTIMER_PRESCALER_EN is defined.
module mytimer_prescaler
   import mytimer_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] prescale_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] limit_q, limit_d;

   assign tick_o = en_i & (cnt_q == limit_q);

   // The limit is only re-sampled at a wrap or restart, so a new PRESCALE
   // never strands the counter above its compare value.
   always_comb begin
      cnt_d   = cnt_q;
      limit_d = limit_q;
      if (clr_i || tick_o) begin
         cnt_d   = '0;
         limit_d = prescale_i;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         limit_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
      end
   end

endmodule

// File: rtl/mytimer_core.sv
// Programmable down-counting timer with a sticky data_ready expiry flag and a chip-select slave port.
// Define MYTIMER_PRESCALER_EN to build the PRESCALE register and prescaler; otherwise it ticks every RUN cycle.
module mytimer_core
   import mytimer_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_cs_n,
   input  logic [2:0]  s_address,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic        data_ready
);

   logic             run_q, run_d;
   logic             cont_q, cont_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      rd_mux;
   logic             wr, rd, start, tick, expire;

   assign wr    = ~s_cs_n & s_write;
   assign rd    = ~s_cs_n & s_read;
   assign start = wr && (s_address == ADDR_CONTROL) && s_writedata[CTRL_START];

`ifdef MYTIMER_PRESCALER_EN
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;

   mytimer_prescaler #(.W(PRESCALE_WIDTH)) u_prescaler (
      .clk_i      (clk),
      .reset_i    (reset),
      .en_i       (run_q),
      .clr_i      (start),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );
`else
   localparam int unused_prescale_w = PRESCALE_WIDTH;
   assign tick = run_q;
`endif

   // Tick handling first, then register writes override; START suppresses the tick.
   always_comb begin
      run_d    = run_q;
      cont_d   = cont_q;
      ready_d  = ready_q;
      period_d = period_q;
      count_d  = count_q;
      expire   = 1'b0;
`ifdef MYTIMER_PRESCALER_EN
      prescale_d = prescale_q;
`endif
      if (tick && !start) begin
         if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            expire = 1'b1;
            if (cont_q) count_d = period_q;
            else        run_d   = 1'b0;
         end
      end
      if (wr) begin
         case (s_address)
            ADDR_CONTROL: begin
               cont_d = s_writedata[CTRL_CONT];
               if (s_writedata[CTRL_START]) begin
                  run_d   = 1'b1;
                  count_d = period_q;
               end else begin
                  run_d = s_writedata[CTRL_RUN];
               end
            end
            ADDR_STATUS: if (s_writedata[STAT_READY]) ready_d = 1'b0;
            ADDR_PERIOD: period_d = s_writedata[WIDTH-1:0];
`ifdef MYTIMER_PRESCALER_EN
            ADDR_PRESCALE: prescale_d = s_writedata[PRESCALE_WIDTH-1:0];
`endif
            default: ;
         endcase
      end
      if (expire) ready_d = 1'b1;
   end

   always_comb begin
      rd_mux = '0;
      case (s_address)
         ADDR_CONTROL: begin
            rd_mux[CTRL_RUN]  = run_q;
            rd_mux[CTRL_CONT] = cont_q;
         end
         ADDR_STATUS: rd_mux[STAT_READY] = ready_q;
         ADDR_PERIOD: rd_mux[WIDTH-1:0]  = period_q;
`ifdef MYTIMER_PRESCALER_EN
         ADDR_PRESCALE: rd_mux[PRESCALE_WIDTH-1:0] = prescale_q;
`endif
         ADDR_COUNT: rd_mux[WIDTH-1:0] = count_q;
         default: ;
      endcase
      rdata_d = rd ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q      <= 1'b0;
         cont_q     <= 1'b0;
         ready_q    <= 1'b0;
         period_q   <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
`ifdef MYTIMER_PRESCALER_EN
         prescale_q <= '0;
`endif
      end else begin
         run_q      <= run_d;
         cont_q     <= cont_d;
         ready_q    <= ready_d;
         period_q   <= period_d;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
`ifdef MYTIMER_PRESCALER_EN
         prescale_q <= prescale_d;
`endif
      end
   end

   assign s_readdata = rdata_q;
   assign data_ready = ready_q;

endmodule

// File: tb/tb_mytimer_core.sv
// Self-checking bench for mytimer_core: register table, directed corner sequences, randomized schedule check.
// Works with or without MYTIMER_PRESCALER_EN.
`timescale 1ns/1ps
module tb_mytimer_core;
   import mytimer_pkg::*;

`ifdef MYTIMER_PRESCALER_EN
   localparam bit PS_EN = 1'b1;
`else
   localparam bit PS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_cs_n = 1'b1;
   logic [2:0]  s_address = 3'd0;
   logic        s_read = 1'b0;
   logic [31:0] s_readdata;
   logic        s_write = 1'b0;
   logic [31:0] s_writedata = 32'd0;
   logic        data_ready;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mytimer_core #(.WIDTH(32), .PRESCALE_WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_cs_n      (s_cs_n),
      .s_address   (s_address),
      .s_read      (s_read),
      .s_readdata  (s_readdata),
      .s_write     (s_write),
      .s_writedata (s_writedata),
      .data_ready  (data_ready)
   );

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
      step(1);
      s_cs_n = 1'b1; s_write = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
      step(1);
      s_cs_n = 1'b1; s_read = 1'b0;
      d = s_readdata;
   endtask

   task automatic stop_timer();
      wr_reg(ADDR_CONTROL, 32'd0);
      wr_reg(ADDR_STATUS, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rv;
      int          L, t, rises, ps, per, ncyc, last_exp, last_clr;
      bit          cont, exp_rdy, clr_next, any_high, do_clr;

      vecs[0] = '{ADDR_PERIOD,   32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{ADDR_PERIOD,   32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[2] = '{ADDR_CONTROL,  32'hFFFF_FFF2, 32'h0000_0002};
      vecs[3] = '{ADDR_CONTROL,  32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{ADDR_PRESCALE, 32'hABCD_0007, PS_EN ? 32'h0000_0007 : 32'h0};
      vecs[5] = '{3'd5,          32'hFFFF_FFFF, 32'h0};
      vecs[6] = '{3'd6,          32'h0000_0001, 32'h0};
      vecs[7] = '{3'd7,          32'hFFFF_FFFF, 32'h0};
      vecs[8] = '{ADDR_COUNT,    32'h0000_1234, 32'h0};
      vecs[9] = '{ADDR_STATUS,   32'h0000_0001, 32'h0};

      // Reset state
      step(2);
      chk("reset_readdata", s_readdata, 32'h0);
      chk("reset_ready", 32'(data_ready), 32'h0);
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd_reg(3'(a), rv);
         chk($sformatf("reset_reg%0d", a), rv, 32'h0);
      end

      // Register write/readback table
      for (int i = 0; i < 10; i++) begin
         wr_reg(vecs[i].addr, vecs[i].wdata);
         rd_reg(vecs[i].addr, rv);
         chk($sformatf("table%0d", i), rv, vecs[i].exp);
      end
      step(3);
      chk("readdata_hold", s_readdata, vecs[9].exp);
      wr_reg(ADDR_PERIOD, 32'h0000_0007);
      rd_reg(ADDR_PERIOD, rv);
      step(2);
      chk("readdata_hold2", s_readdata, 32'h7);

      // One-shot: PERIOD=3, PRESCALE=0
      wr_reg(ADDR_PERIOD, 32'd3);
      wr_reg(ADDR_PRESCALE, 32'd0);
      wr_reg(ADDR_CONTROL, 32'h4);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk($sformatf("oneshot_t%0d", k), 32'(data_ready), 32'(k == 4));
      end
      rd_reg(ADDR_CONTROL, rv);
      chk("oneshot_run", rv, 32'h0);
      rd_reg(ADDR_COUNT, rv);
      chk("oneshot_count", rv, 32'h0);
      wr_reg(ADDR_STATUS, 32'h1);
      chk("oneshot_clear", 32'(data_ready), 32'h0);

      // Periodic with prescale, cleared after every rise
      L = 2 * (PS_EN ? 3 : 1);
      wr_reg(ADDR_PERIOD, 32'd1);
      wr_reg(ADDR_PRESCALE, 32'd2);
      wr_reg(ADDR_CONTROL, 32'h6);
      t = 0; clr_next = 1'b0; rises = 0;
      for (int i = 0; i < 5 * L; i++) begin
         if (clr_next) wr_reg(ADDR_STATUS, 32'h1);
         else          step(1);
         t++;
         exp_rdy = (t % L == 0);
         if (data_ready) rises++;
         chk($sformatf("periodic_t%0d", t), 32'(data_ready), 32'(exp_rdy));
         clr_next = exp_rdy;
      end
      chk("periodic_rises", 32'(rises), 32'd5);
      stop_timer();

      // Collision: clear lands on the expiry edge
      wr_reg(ADDR_CONTROL, 32'h6);
      step(L - 1);
      wr_reg(ADDR_STATUS, 32'h1);
      chk("collide_set_wins", 32'(data_ready), 32'h1);
      wr_reg(ADDR_STATUS, 32'h1);
      chk("collide_then_clear", 32'(data_ready), 32'h0);
      stop_timer();

      // Pause at COUNT=5, resume
      wr_reg(ADDR_PRESCALE, 32'd0);
      wr_reg(ADDR_PERIOD, 32'd10);
      wr_reg(ADDR_CONTROL, 32'h4);
      step(4);
      wr_reg(ADDR_CONTROL, 32'h0);
      step(20);
      rd_reg(ADDR_COUNT, rv);
      chk("pause_count", rv, 32'd5);
      chk("pause_ready", 32'(data_ready), 32'h0);
      wr_reg(ADDR_CONTROL, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk($sformatf("resume_t%0d", k), 32'(data_ready), 32'(k == 6));
      end
      stop_timer();

      // Reset mid-count
      wr_reg(ADDR_PERIOD, 32'd100);
      wr_reg(ADDR_CONTROL, 32'h4);
      step(49);
      rd_reg(ADDR_COUNT, rv);
      chk("pre_reset_count", rv, 32'd51);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("midreset_readdata", s_readdata, 32'h0);
      chk("midreset_ready", 32'(data_ready), 32'h0);
      for (int a = 0; a < 5; a++) begin
         rd_reg(3'(a), rv);
         chk($sformatf("midreset_reg%0d", a), rv, 32'h0);
      end
      any_high = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (data_ready) any_high = 1'b1;
      end
      chk("midreset_no_expiry", 32'(any_high), 32'h0);

      // Randomized configurations against the expiry schedule (PERIOD+1)*(PRESCALE+1)
      for (int trial = 0; trial < 40; trial++) begin
         stop_timer();
         per  = int'($urandom_range(0, 5));
         ps   = PS_EN ? int'($urandom_range(0, 3)) : 0;
         cont = 1'($urandom_range(0, 1));
         L    = (per + 1) * (ps + 1);
         wr_reg(ADDR_PERIOD, 32'(per));
         wr_reg(ADDR_PRESCALE, 32'(ps));
         wr_reg(ADDR_CONTROL, {29'd0, 1'b1, cont, 1'b0});
         ncyc = 3 * L + 5;
         last_exp = -1; last_clr = -1;
         for (t = 1; t <= ncyc; t++) begin
            do_clr = ($urandom_range(0, 3) == 0);
            if (do_clr) wr_reg(ADDR_STATUS, 32'h1);
            else        step(1);
            if (t % L == 0 && (cont || t == L)) last_exp = t;
            if (do_clr) last_clr = t;
            exp_rdy = (last_exp >= 0) && (last_clr <= last_exp);
            chk($sformatf("rand%0d_t%0d", trial, t), 32'(data_ready), 32'(exp_rdy));
         end
         rd_reg(ADDR_CONTROL, rv);
         chk($sformatf("rand%0d_ctrl", trial), rv, cont ? 32'h3 : 32'h0);
         if (!cont) begin
            rd_reg(ADDR_COUNT, rv);
            chk($sformatf("rand%0d_count", trial), rv, 32'h0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
